usb_tx_msg_buffer: RTL and testbench

Upstream feeder for the FX2 slave-FIFO read/write controller. Collects 16-bit words from the redirection datapath into a local FIFO and tracks complete fixed-length messages. Advertises a buffered message to the controller and serves words one per read request. Signals the end of the message so the controller returns to idle between messages.

---
 rtl/usb_tx_msg_buffer_pkg.sv | 12 +
 rtl/usb_tx_msg_buffer_if.sv | 27 ++
 rtl/usb_tx_msg_buffer_sync_fifo.sv | 55 +++++
 rtl/usb_tx_msg_buffer.sv | 80 ++++++++
 tb/tb_usb_tx_msg_buffer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_msg_buffer_pkg.sv
// Shared definitions for the USB TX message buffer: data width, message defaults
// and the input FSM state encoding.
package usb_tx_msg_buffer_pkg;
    localparam int          DATA_W        = 16;
    localparam int          MSG_WORDS_DEF = 256;
    localparam logic [15:0] PAD_WORD_DEF  = 16'h0000;

    typedef enum logic {
        ACCEPT = 1'b0,
        PAD    = 1'b1
    } in_state_t;
endpackage

// File: rtl/usb_tx_msg_buffer_if.sv
// Datapath-side and controller-side signals of the USB TX message buffer.
// The master modport is the feeder/controller; the slave modport is the buffer.
interface usb_tx_msg_buffer_if #(parameter int DEPTH = 1024);
    import usb_tx_msg_buffer_pkg::*;

    logic [DATA_W-1:0]      DIN;
    logic                   DIN_VALID;
    logic                   DIN_READY;
    logic                   FLUSH;
    logic                   fifo_rdrq;
    logic [DATA_W-1:0]      fifo_q;
    logic                   GOT_FULL_MSG;
    logic                   READ_ALLOW;
    logic                   OVERFLOW;
    logic                   UNDERFLOW;
    logic [$clog2(DEPTH):0] used_words;

    modport master (
        output DIN, DIN_VALID, FLUSH, fifo_rdrq,
        input  DIN_READY, fifo_q, GOT_FULL_MSG, READ_ALLOW, OVERFLOW, UNDERFLOW, used_words
    );

    modport slave (
        input  DIN, DIN_VALID, FLUSH, fifo_rdrq,
        output DIN_READY, fifo_q, GOT_FULL_MSG, READ_ALLOW, OVERFLOW, UNDERFLOW, used_words
    );
endinterface

// File: rtl/usb_tx_msg_buffer_sync_fifo.sv
// Single-clock FIFO with registered read data updated on an accepted rdreq.
// Writes when full and reads when empty are ignored.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   wrreq,
    input  logic [DATA_W-1:0]      data,
    input  logic                   rdreq,
    output logic [DATA_W-1:0]      q,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] usedw
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              wr_ok;
    logic              rd_ok;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign usedw = cnt;
    assign wr_ok = wrreq & ~full;
    assign rd_ok = rdreq & ~empty;

    always_ff @(posedge CLK) begin
        if (wr_ok) mem[wr_ptr] <= data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            q      <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                q      <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/usb_tx_msg_buffer.sv
// Buffers 16-bit words into fixed-length messages for the FX2 slave-FIFO controller,
// with flush-to-boundary padding and sticky overflow/underflow flags.
module usb_tx_msg_buffer
    import usb_tx_msg_buffer_pkg::*;
#(
    parameter int                DEPTH     = 1024,
    parameter int                MSG_WORDS = MSG_WORDS_DEF,
    parameter logic [DATA_W-1:0] PAD_WORD  = PAD_WORD_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    usb_tx_msg_buffer_if.slave  bus
);
    localparam int MW = $clog2(MSG_WORDS);
    localparam int CW = $clog2(DEPTH / MSG_WORDS) + 1;

    in_state_t         state;
    logic [MW-1:0]     push_cnt;
    logic [MW-1:0]     pop_cnt;
    logic [MW-1:0]     push_cnt_nxt;
    logic [CW-1:0]     msg_cnt;
    logic              full;
    logic              empty;
    logic              wr_en;
    logic              rd_en;
    logic              push_wrap;
    logic              msg_start;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        wr_en        = ~full & (((state == ACCEPT) & bus.DIN_VALID) | (state == PAD));
        wr_data      = (state == PAD) ? PAD_WORD : bus.DIN;
        // A pop is only honoured when a message is in progress or one is complete.
        rd_en        = bus.fifo_rdrq & ((pop_cnt != '0) | (msg_cnt != '0));
        push_wrap    = wr_en & (push_cnt == MW'(MSG_WORDS - 1));
        msg_start    = rd_en & (pop_cnt == '0);
        push_cnt_nxt = push_cnt + MW'(wr_en);
    end

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .wrreq (wr_en),
        .data  (wr_data),
        .rdreq (rd_en),
        .q     (bus.fifo_q),
        .full  (full),
        .empty (empty),
        .usedw (bus.used_words)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ACCEPT;
            push_cnt      <= '0;
            pop_cnt       <= '0;
            msg_cnt       <= '0;
            bus.OVERFLOW  <= 1'b0;
            bus.UNDERFLOW <= 1'b0;
        end else begin
            push_cnt <= push_cnt_nxt;
            if (rd_en) pop_cnt <= pop_cnt + 1'b1;
            if (push_wrap & ~msg_start)      msg_cnt <= msg_cnt + 1'b1;
            else if (~push_wrap & msg_start) msg_cnt <= msg_cnt - 1'b1;
            if ((state == ACCEPT) & bus.DIN_VALID & full) bus.OVERFLOW <= 1'b1;
            if (bus.fifo_rdrq & ~rd_en)                   bus.UNDERFLOW <= 1'b1;
            case (state)
                // Judge the flush against the count after this edge's write, so a
                // write that just closed a message does not trigger a full pad.
                ACCEPT:  if (bus.FLUSH && push_cnt_nxt != '0) state <= PAD;
                PAD:     if (push_wrap) state <= ACCEPT;
                default: state <= ACCEPT;
            endcase
        end
    end

    assign bus.DIN_READY    = (state == ACCEPT) & ~full;
    assign bus.GOT_FULL_MSG = (msg_cnt != '0) & (pop_cnt == '0);
    assign bus.READ_ALLOW   = (pop_cnt != '0);
endmodule

// File: tb/tb_usb_tx_msg_buffer.sv
// Scoreboard bench for usb_tx_msg_buffer: directed stimulus feeds a reference
// queue; a monitor checks fifo_q after every issued pop.
module tb_usb_tx_msg_buffer;
    localparam int          DEPTH = 1024;
    localparam int          MSG   = 256;
    localparam logic [15:0] PADW  = 16'h0000;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    usb_tx_msg_buffer_if #(.DEPTH(DEPTH)) bif ();

    usb_tx_msg_buffer #(.DEPTH(DEPTH), .MSG_WORDS(MSG), .PAD_WORD(PADW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bif)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] mq [$];
    logic [15:0] sb [$];
    logic [15:0] last_q = 16'h0;
    int          m_push = 0, m_pop = 0, m_msg = 0;
    bit          m_ovf = 0, m_unf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, " used_words"}, 32'(bif.used_words), 32'(mq.size()));
        chk({tag, " GOT_FULL_MSG"}, 32'(bif.GOT_FULL_MSG), 32'(m_msg != 0 && m_pop == 0));
        chk({tag, " READ_ALLOW"}, 32'(bif.READ_ALLOW), 32'(m_pop != 0));
        chk({tag, " OVERFLOW"}, 32'(bif.OVERFLOW), 32'(m_ovf));
        chk({tag, " UNDERFLOW"}, 32'(bif.UNDERFLOW), 32'(m_unf));
    endtask

    // One cycle in ACCEPT: optional push and/or pop, reference model updated alongside.
    task automatic step(input bit push, input logic [15:0] d, input bit pop, input string tag);
        bit wr, rd;
        wr = push && (mq.size() < DEPTH);
        rd = pop && (m_pop != 0 || m_msg != 0);
        if (push) chk({tag, " DIN_READY"}, 32'(bif.DIN_READY), 32'(wr));
        bif.DIN       = d;
        bif.DIN_VALID = push;
        bif.fifo_rdrq = pop;
        if (rd) begin
            last_q = mq.pop_front();
            sb.push_back(last_q);
        end else if (pop) begin
            sb.push_back(last_q);
        end
        if (wr) mq.push_back(d);
        tick();
        bif.DIN_VALID = 1'b0;
        bif.fifo_rdrq = 1'b0;
        if (wr && m_push == MSG - 1) m_msg++;
        if (rd && m_pop == 0) m_msg--;
        if (wr) m_push = (m_push + 1) % MSG;
        if (rd) m_pop = (m_pop + 1) % MSG;
        if (push && !wr) m_ovf = 1;
        if (pop && !rd) m_unf = 1;
        chk_state(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_push = 0; m_pop = 0; m_msg = 0;
        m_ovf = 0; m_unf = 0;
        last_q = 16'h0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " fifo_q"}, 32'(bif.fifo_q), 32'h0);
        chk({tag, " DIN_READY"}, 32'(bif.DIN_READY), 32'h1);
        chk({tag, " GOT_FULL_MSG"}, 32'(bif.GOT_FULL_MSG), 32'h0);
        chk({tag, " READ_ALLOW"}, 32'(bif.READ_ALLOW), 32'h0);
        chk({tag, " OVERFLOW"}, 32'(bif.OVERFLOW), 32'h0);
        chk({tag, " UNDERFLOW"}, 32'(bif.UNDERFLOW), 32'h0);
        chk({tag, " used_words"}, 32'(bif.used_words), 32'h0);
    endtask

    // Monitor: after every edge that sampled a pop request, fifo_q must match the scoreboard.
    always @(posedge CLK) begin
        if (bif.fifo_rdrq === 1'b1) begin
            #1;
            if (sb.size() == 0) begin
                chk("fifo_q no expectation", 32'(bif.fifo_q), 32'hFFFF_FFFF);
            end else begin
                chk("fifo_q", 32'(bif.fifo_q), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        bif.DIN       = '0;
        bif.DIN_VALID = 1'b0;
        bif.FLUSH     = 1'b0;
        bif.fifo_rdrq = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        RST = 1'b0;
        tick();

        // Full message with no gaps, then 256 spaced pops.
        for (int i = 0; i < MSG; i++) begin
            if (i == MSG - 1) chk("msg1 GOT before last", 32'(bif.GOT_FULL_MSG), 32'h0);
            step(1, 16'(i), 0, "msg1 push");
        end
        chk("msg1 GOT after last", 32'(bif.GOT_FULL_MSG), 32'h1);
        for (int i = 0; i < MSG; i++) begin
            step(0, 16'h0, 1, "msg1 pop");
            if (i == 0) chk("msg1 GOT after pop1", 32'(bif.GOT_FULL_MSG), 32'h0);
            chk("msg1 READ_ALLOW", 32'(bif.READ_ALLOW), 32'(i != MSG - 1));
            step(0, 16'h0, 0, "msg1 gap");
            step(0, 16'h0, 0, "msg1 gap");
        end

        // Partial message of 100 words, then flush pads 156 words.
        for (int i = 0; i < 100; i++) step(1, 16'(16'h0A00 + i), 0, "flush push");
        bif.FLUSH = 1'b1;
        tick();
        bif.FLUSH = 1'b0;
        for (int i = 0; i < MSG - 100; i++) begin
            chk("flush DIN_READY low", 32'(bif.DIN_READY), 32'h0);
            chk("flush GOT low", 32'(bif.GOT_FULL_MSG), 32'h0);
            tick();
            mq.push_back(PADW);
            m_push = (m_push + 1) % MSG;
        end
        m_msg++;
        chk("flush DIN_READY back", 32'(bif.DIN_READY), 32'h1);
        chk("flush GOT high", 32'(bif.GOT_FULL_MSG), 32'h1);
        chk("flush used_words", 32'(bif.used_words), 32'd256);
        for (int i = 0; i < MSG; i++) step(0, 16'h0, 1, "flush drain");

        // Fill four messages and offer one more word.
        for (int i = 0; i < DEPTH; i++) step(1, 16'(16'h1000 + i), 0, "fill");
        step(1, 16'hDEAD, 0, "overflow");
        chk("ovf OVERFLOW", 32'(bif.OVERFLOW), 32'h1);
        chk("ovf used_words", 32'(bif.used_words), 32'd1024);
        chk("ovf DIN_READY", 32'(bif.DIN_READY), 32'h0);
        chk("ovf GOT", 32'(bif.GOT_FULL_MSG), 32'h1);

        // Drain message 1 while writing message 5.
        step(0, 16'h0, 1, "conc pop");
        for (int i = 0; i < MSG - 1; i++) step(1, 16'(16'h2000 + i), 1, "conc both");
        step(1, 16'(16'h2000 + MSG - 1), 0, "conc push");
        chk("conc used_words", 32'(bif.used_words), 32'd1024);
        chk("conc GOT", 32'(bif.GOT_FULL_MSG), 32'h1);
        chk("conc READ_ALLOW", 32'(bif.READ_ALLOW), 32'h0);
        for (int i = 0; i < DEPTH; i++) step(0, 16'h0, 1, "conc drain");
        chk("drained used_words", 32'(bif.used_words), 32'h0);

        // Pop on an empty FIFO.
        step(0, 16'h0, 1, "underflow");
        chk("unf UNDERFLOW", 32'(bif.UNDERFLOW), 32'h1);
        chk("unf READ_ALLOW", 32'(bif.READ_ALLOW), 32'h0);
        chk("unf fifo_q held", 32'(bif.fifo_q), 32'(16'h2000 + MSG - 1));

        // Reset in the middle of a message.
        for (int i = 0; i < 300; i++) step(1, 16'(16'h3000 + i), 0, "pre-rst push");
        for (int i = 0; i < 10; i++) step(0, 16'h0, 1, "pre-rst pop");
        tick();
        RST = 1'b1;
        #2;
        chk_reset_outputs("midrst");
        model_reset();
        tick();
        RST = 1'b0;
        tick();
        for (int i = 0; i < MSG; i++) step(1, 16'(16'h4000 + i), 0, "post-rst push");
        chk("post-rst GOT", 32'(bif.GOT_FULL_MSG), 32'h1);
        step(0, 16'h0, 1, "post-rst pop");
        chk("post-rst single msg", 32'(bif.GOT_FULL_MSG), 32'h0);
        for (int i = 1; i < MSG; i++) step(0, 16'h0, 1, "post-rst pop");
        chk("post-rst READ_ALLOW", 32'(bif.READ_ALLOW), 32'h0);
        chk("post-rst used_words", 32'(bif.used_words), 32'h0);

        tick();
        tick();
        chk("scoreboard empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
